// File: rtl/matmul_pkg.sv
// Shared state type and arithmetic helpers for matrix_mac_engine.
// Build with SATURATE_EN defined to clamp C elements to the element range instead of wrapping.
package matmul_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    // Widest accumulator the reduction helper accepts.
    localparam int MAX_ACC_W = 256;

    function automatic int acc_width(input int width, input int p);
        return 2 * width + $clog2(p) + 1;
    endfunction

    function automatic logic signed [MAX_ACC_W-1:0] sat_or_wrap(
        input logic signed [MAX_ACC_W-1:0] acc,
        input int                          width
    );
`ifdef SATURATE_EN
        logic signed [MAX_ACC_W-1:0] hi;
        logic signed [MAX_ACC_W-1:0] lo;
        hi = (MAX_ACC_W'(1) <<< (width - 1)) - MAX_ACC_W'(1);
        lo = -hi - MAX_ACC_W'(1);
        if (acc > hi)
            return hi;
        else if (acc < lo)
            return lo;
        else
            return acc;
`else
        return acc & ((MAX_ACC_W'(1) <<< width) - MAX_ACC_W'(1));
`endif
    endfunction

endpackage

// File: rtl/mac_lane.sv
// Signed multiply-accumulate lane; the accumulator restarts on the first term of each dot product.
// sum is the combinational next value so the owner can write back on the last term with no extra cycle.
module mac_lane
    import matmul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ACC_W = 69
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    first,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [ACC_W-1:0] sum
);

    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   base;
    logic signed [2*WIDTH-1:0] prod;

    always_comb begin
        prod = (2*WIDTH)'(a) * (2*WIDTH)'(b);
        base = first ? '0 : acc;
        sum  = base + ACC_W'(prod);
    end

    always_ff @(posedge clk) begin
        if (!rst)
            acc <= '0;
        else if (en)
            acc <= sum;
    end

endmodule

// File: rtl/matrix_mac_engine.sv
// C = A * B on signed elements with LANES MAC lanes, swept column-major over row groups; stb/ack handshakes.
// Reduction of the wide sum to WIDTH wraps by default, or saturates when SATURATE_EN is defined.
module matrix_mac_engine
    import matmul_pkg::*;
#(
    parameter int M     = 16,
    parameter int P     = 16,
    parameter int N     = 16,
    parameter int WIDTH = 32,
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [M*P*WIDTH-1:0] matrix_A,
    input  logic                 a_stb,
    output logic                 a_ack,
    input  logic [P*N*WIDTH-1:0] matrix_B,
    input  logic                 b_stb,
    output logic                 b_ack,
    output logic [M*N*WIDTH-1:0] matrix_C,
    output logic                 c_stb,
    input  logic                 c_ack,
    output logic                 busy
);

    localparam int G     = M / LANES;
    localparam int ACC_W = acc_width(WIDTH, P);
    localparam int JW    = (N > 1) ? $clog2(N) : 1;
    localparam int GW    = (G > 1) ? $clog2(G) : 1;
    localparam int KW    = (P > 1) ? $clog2(P) : 1;

    if (M % LANES != 0) begin : g_bad_lanes
        $error("matrix_mac_engine: M must be a multiple of LANES");
    end

    state_t               state;
    logic [M*P*WIDTH-1:0] a_reg;
    logic [P*N*WIDTH-1:0] b_reg;
    logic [JW-1:0]        j;
    logic [GW-1:0]        g;
    logic [KW-1:0]        k;
    logic [LANES*WIDTH-1:0] wr_flat;
    logic signed [WIDTH-1:0] opb;
    logic                 calc_en;
    logic                 last_k;
    int                   b_idx;

    assign calc_en = (state == CALC);
    assign last_k  = (k == KW'(P - 1));

    // Every lane multiplies by the same B(k,j); only the A row differs.
    always_comb begin
        b_idx = (int'(k) * N + int'(j)) * WIDTH;
        opb   = b_reg[b_idx +: WIDTH];
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        int                      a_idx;
        logic signed [WIDTH-1:0] opa;
        logic signed [ACC_W-1:0] sum;

        always_comb begin
            a_idx = ((int'(g) * LANES + l) * P + int'(k)) * WIDTH;
            opa   = a_reg[a_idx +: WIDTH];
        end

        mac_lane #(.WIDTH(WIDTH), .ACC_W(ACC_W)) u_mac (
            .clk   (clk),
            .rst   (rst),
            .en    (calc_en),
            .first (k == '0),
            .a     (opa),
            .b     (opb),
            .sum   (sum)
        );

        assign wr_flat[l*WIDTH +: WIDTH] = WIDTH'(sat_or_wrap(MAX_ACC_W'(sum), WIDTH));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            c_stb    <= 1'b0;
            busy     <= 1'b0;
            matrix_C <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            j        <= '0;
            g        <= '0;
            k        <= '0;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (a_stb && b_stb) begin
                        a_reg <= matrix_A;
                        b_reg <= matrix_B;
                        a_ack <= 1'b1;
                        b_ack <= 1'b1;
                        busy  <= 1'b1;
                        j     <= '0;
                        g     <= '0;
                        k     <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (last_k) begin
                        for (int l = 0; l < LANES; l++)
                            matrix_C[((int'(g) * LANES + l) * N + int'(j)) * WIDTH +: WIDTH]
                                <= wr_flat[l*WIDTH +: WIDTH];
                        k <= '0;
                        if (g == GW'(G - 1)) begin
                            g <= '0;
                            if (j == JW'(N - 1)) begin
                                c_stb <= 1'b1;
                                state <= DONE;
                            end else begin
                                j <= j + JW'(1);
                            end
                        end else begin
                            g <= g + GW'(1);
                        end
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DONE: begin
                    if (c_ack) begin
                        c_stb <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
